// File: rtl/noc_port_demux.sv
// noc_port_demux: distributes one flit stream over PORT_NUM output channels.
// The head flit's binary destination is decoded to a one-hot select, and the
// packet (head..tail) stays locked to that port. Each output owns a one-entry
// valid/ready register stage. Heads with an out-of-range destination are
// accepted and discarded together with the rest of their packet.
// Optional feature: define NOC_DEMUX_DROP_CNT_EN to build the saturating
// dropped-packet counter on drop_cnt; otherwise drop_cnt is tied to zero.
module noc_port_demux #(
  parameter int unsigned PORT_NUM   = 5,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_W      = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]               in_dst,
  input  logic                           in_last,
  output logic [PORT_NUM-1:0]            out_valid,
  input  logic [PORT_NUM-1:0]            out_ready,
  output logic [PORT_NUM*DATA_WIDTH-1:0] out_data,
  output logic                           busy,
  output logic                           drop_err,
  output logic [15:0]                    drop_cnt
);

  typedef enum logic [1:0] {IDLE, FWD, DROP} state_e;

  state_e                state_q, state_d;
  logic [PORT_NUM-1:0]   sel_q, sel_d;
  logic                  drop_err_q, drop_err_d;
  logic [PORT_NUM-1:0]   out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] data_q [PORT_NUM];
  logic [DATA_WIDTH-1:0] data_d [PORT_NUM];

  logic [PORT_NUM-1:0]   sel_idle;
  logic                  dst_legal;
  logic [PORT_NUM-1:0]   select;
  logic [PORT_NUM-1:0]   stage_free;
  logic [PORT_NUM-1:0]   load;
  logic                  accept;

  // Destination decode, active port select and input-side ready.
  always_comb begin
    sel_idle = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      if (32'(in_dst) == i) sel_idle[i] = 1'b1;
    end
    // An out-of-range destination matches no port and leaves sel_idle empty.
    dst_legal = |sel_idle;
    case (state_q)
      IDLE:    select = sel_idle;
      FWD:     select = sel_q;
      default: select = '0;
    endcase
    stage_free = ~out_valid_q | out_ready;
    in_ready   = (state_q == DROP) || ((state_q == IDLE) && !dst_legal) ||
                 (|(select & stage_free));
    accept     = in_valid & in_ready;
    load       = accept ? select : '0;
  end

  // Packet lock FSM: next state, latched select and drop pulse.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    drop_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (dst_legal) begin
            if (!in_last) begin
              state_d = FWD;
              sel_d   = sel_idle;
            end
          end else begin
            drop_err_d = 1'b1;
            if (!in_last) state_d = DROP;
          end
        end
      end
      FWD, DROP: begin
        if (accept && in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-port output stages: a load wins over a drain, so a drain and reload
  // in the same cycle leaves no bubble.
  always_comb begin
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      out_valid_d[i] = load[i] | (out_valid_q[i] & ~out_ready[i]);
      data_d[i]      = load[i] ? in_data : data_q[i];
    end
  end

  // State, lock and output stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      drop_err_q  <= 1'b0;
      out_valid_q <= '0;
      for (int unsigned i = 0; i < PORT_NUM; i++) data_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      drop_err_q  <= drop_err_d;
      out_valid_q <= out_valid_d;
      for (int unsigned i = 0; i < PORT_NUM; i++) data_q[i] <= data_d[i];
    end
  end

`ifdef NOC_DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped packets, stepping with each drop pulse.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_err_d && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = '0;
`endif

  // Flatten the per-port stages onto the output bus.
  always_comb begin
    out_data = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      out_data[i*DATA_WIDTH +: DATA_WIDTH] = data_q[i];
    end
  end

  assign out_valid = out_valid_q;
  assign busy      = (state_q != IDLE);
  assign drop_err  = drop_err_q;

endmodule

// File: tb/tb_noc_port_demux.sv
// Testbench for noc_port_demux (PORT_NUM=5, DATA_WIDTH=32): directed cases
// followed by random traffic, all checked against a packet-level model.
module tb_noc_port_demux;

  localparam int NP = 5;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic [2:0]      in_dst;
  logic            in_last;
  logic [NP-1:0]   out_valid;
  logic [NP-1:0]   out_ready;
  logic [NP*DW-1:0] out_data;
  logic            busy;
  logic            drop_err;
  logic [15:0]     drop_cnt;

  noc_port_demux #(.PORT_NUM(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dst(in_dst), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .drop_err(drop_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Reference model: packet-level view.
  bit          m_in_pkt;     // inside a multi-flit packet
  int          m_port;       // locked port, -1 = packet being discarded
  bit          m_vld [NP];
  logic [DW-1:0] m_dat [NP];
  bit          m_derr;
  int          m_cnt;

  task automatic model_reset();
    m_in_pkt = 0; m_port = -1; m_derr = 0; m_cnt = 0;
    for (int i = 0; i < NP; i++) begin m_vld[i] = 0; m_dat[i] = '0; end
  endtask

  function automatic int target_port(input logic [2:0] dst);
    if (m_in_pkt) return m_port;
    return (int'(dst) < NP) ? int'(dst) : -1;
  endfunction

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [NP-1:0]    ev;
    logic [NP*DW-1:0] ed;
    int               ecnt;
    for (int i = 0; i < NP; i++) begin
      ev[i] = m_vld[i];
      ed[i*DW +: DW] = m_dat[i];
    end
`ifdef NOC_DEMUX_DROP_CNT_EN
    ecnt = (m_cnt > 65535) ? 65535 : m_cnt;
`else
    ecnt = 0;
`endif
    chk({tag, "_out_valid"}, 192'(out_valid), 192'(ev));
    chk({tag, "_out_data"},  192'(out_data),  192'(ed));
    chk({tag, "_busy"},      192'(busy),      192'(m_in_pkt));
    chk({tag, "_drop_err"},  192'(drop_err),  192'(m_derr));
    chk({tag, "_drop_cnt"},  192'(drop_cnt),  192'(ecnt));
  endtask

  // One clock: drive inputs, check in_ready, advance model, check outputs.
  task automatic cycle(input string tag, input bit v, input logic [DW-1:0] d,
                       input logic [2:0] dst, input bit last, input logic [NP-1:0] ordy);
    int p;
    bit exp_rdy, acc;
    in_valid = v; in_data = d; in_dst = dst; in_last = last; out_ready = ordy;
    #1;
    p = target_port(dst);
    exp_rdy = (p < 0) ? 1'b1 : (!m_vld[p] || ordy[p]);
    chk({tag, "_in_ready"}, 192'(in_ready), 192'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk); #1;
    for (int i = 0; i < NP; i++) if (ordy[i]) m_vld[i] = 0;
    m_derr = 0;
    if (acc) begin
      if (p >= 0) begin m_vld[p] = 1; m_dat[p] = d; end
      if (!m_in_pkt) begin
        if (p < 0) begin m_derr = 1; m_cnt++; end
        if (!last) begin m_in_pkt = 1; m_port = p; end
      end else if (last) begin
        m_in_pkt = 0;
      end
    end
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 0; in_data = '0; in_dst = '0; in_last = 0; out_ready = '0;
    model_reset();
    #1;
    check_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: two-flit packet to port 3
    cycle("t1_head", 1, 32'hA1, 3'd3, 0, '1);
    chk("t1_ov_head", 192'(out_valid), 192'(5'b01000));
    chk("t1_busy_head", 192'(busy), 192'(1'b1));
    cycle("t1_tail", 1, 32'hB2, 3'd3, 1, '1);
    chk("t1_data_tail", 192'(out_data[3*DW +: DW]), 192'(32'hB2));
    chk("t1_busy_tail", 192'(busy), 192'(1'b0));
    cycle("t1_idle", 0, '0, 3'd0, 0, '1);

    // 2: port 2 blocked downstream
    cycle("t2_p1", 1, 32'hC3, 3'd2, 1, 5'b11011);
    cycle("t2_blk0", 1, 32'hD4, 3'd2, 1, 5'b11011);
    chk("t2_rdy_blocked", 192'(in_ready), 192'(1'b0));
    cycle("t2_blk1", 1, 32'hD4, 3'd2, 1, 5'b11011);
    cycle("t2_open", 1, 32'hD4, 3'd2, 1, '1);
    chk("t2_data", 192'(out_data[2*DW +: DW]), 192'(32'hD4));
    cycle("t2_idle", 0, '0, 3'd0, 0, '1);

    // 3: dst changes on body flits
    cycle("t3_head", 1, 32'h11, 3'd1, 0, '1);
    cycle("t3_body", 1, 32'h12, 3'd4, 0, '1);
    cycle("t3_tail", 1, 32'h13, 3'd4, 1, '1);
    chk("t3_ov", 192'(out_valid), 192'(5'b00010));
    cycle("t3_idle", 0, '0, 3'd0, 0, '1);

    // 4: illegal destination, three flits
    cycle("t4_head", 1, 32'h21, 3'd7, 0, '1);
    chk("t4_drop_err", 192'(drop_err), 192'(1'b1));
    cycle("t4_body", 1, 32'h22, 3'd0, 0, '1);
    cycle("t4_tail", 1, 32'h23, 3'd0, 1, '1);
    chk("t4_ov", 192'(out_valid), 192'(5'b00000));
    cycle("t4_idle", 0, '0, 3'd0, 0, '1);

    // 5: reset in the middle of a packet
    cycle("t5_head", 1, 32'h31, 3'd0, 0, '1);
    in_valid = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("t5_rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    cycle("t5_new", 1, 32'h32, 3'd2, 1, '1);
    chk("t5_ov", 192'(out_valid), 192'(5'b00100));

    // 6: back-to-back single-flit packets
    cycle("t6_a", 1, 32'h41, 3'd0, 1, '1);
    cycle("t6_b", 1, 32'h42, 3'd1, 1, '1);
    cycle("t6_c", 1, 32'h43, 3'd2, 1, '1);
    cycle("t6_d", 1, 32'h44, 3'd0, 1, '1);
    chk("t6_ov", 192'(out_valid), 192'(5'b00001));
    cycle("t6_idle", 0, '0, 3'd0, 0, '1);

    // Random traffic, including illegal destinations and backpressure.
    for (int n = 0; n < 400; n++) begin
      cycle("rnd", ($urandom_range(0, 3) != 0), DW'($urandom), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) == 0), NP'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
